i2c_slave_rx: RTL and testbench



---
 rtl/i2c_slave_rx.sv | 185 ++++++++++++++++++
 tb/tb_i2c_slave_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx
// Write-only I2C target. Receives <device byte> <register byte> <data byte>...
// from an external controller and reports every data byte, together with the
// register address it belongs to, as a one-cycle strobe to internal logic.
// SCL and SDA are oversampled by clk. There is no clock stretching and no
// read support.
//
// Parameters:
//   DEV_ADDR       7-bit device address this target answers to (default 7'h1A)
// Ports:
//   clk            system clock, all logic on its rising edge
//   rst            synchronous, active-high reset
//   pin_scl        I2C SCL, asynchronous to clk
//   pin_sda        I2C SDA, open-drain: driven only as 0, otherwise high-Z
//   addr           register address reported with the latest data byte
//   data_in        most recently received data byte
//   data_in_ready  one-cycle strobe: addr/data_in hold a new pair
// Build option:
//   I2C_SLAVE_AUTO_INC_EN  when defined, the register address advances by one
//                          (8-bit wrap) after every reported data byte.
module i2c_slave_rx #(
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pin_scl,
  inout  wire        pin_sda,
  output logic [7:0] addr,
  output logic [7:0] data_in,
  output logic       data_in_ready
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_REG_ADDR,
    ST_REG_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE
  } state_t;

  state_t      state_q, state_d;
  logic        scl_meta_q, scl_sync_q, scl_prev_q;
  logic        sda_meta_q, sda_sync_q, sda_prev_q;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        have_bit_q, have_bit_d;
  logic        sda_oe_q, sda_oe_d;
  logic [7:0]  reg_ptr_q, reg_ptr_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_in_q, data_in_d;
  logic        data_in_ready_q, data_in_ready_d;

  logic scl_rise, scl_fall, bus_start, bus_stop;

  // Open-drain SDA: only ever pull low, otherwise leave the line to the pull-up.
  assign pin_sda = sda_oe_q ? 1'b0 : 1'bz;

  assign addr          = addr_q;
  assign data_in       = data_in_q;
  assign data_in_ready = data_in_ready_q;

  // Edges are taken between the second synchronizer stage and its delayed
  // copy, so an event is acted on three clk cycles after the pin changes.
  // START/STOP need SCL high on both samples so an SDA change while SCL is low
  // stays an ordinary data transition.
  assign scl_rise  =  scl_sync_q & ~scl_prev_q;
  assign scl_fall  = ~scl_sync_q &  scl_prev_q;
  assign bus_start =  scl_sync_q &  scl_prev_q &  sda_prev_q & ~sda_sync_q;
  assign bus_stop  =  scl_sync_q &  scl_prev_q & ~sda_prev_q &  sda_sync_q;

  // Next-state logic. have_bit_q records that a bit was sampled since the last
  // SCL fall, so the fall that follows a START (before any bit) does not
  // advance the bit counter. The byte completes on the fall after the 8th
  // sampled bit; that same fall starts the ACK, and the next fall ends it.
  always_comb begin
    state_d         = state_q;
    shift_d         = shift_q;
    bit_cnt_d       = bit_cnt_q;
    have_bit_d      = have_bit_q;
    sda_oe_d        = sda_oe_q;
    reg_ptr_d       = reg_ptr_q;
    addr_d          = addr_q;
    data_in_d       = data_in_q;
    data_in_ready_d = 1'b0;

    if (bus_start) begin
      state_d    = ST_DEV_ADDR;
      bit_cnt_d  = 3'd0;
      have_bit_d = 1'b0;
      sda_oe_d   = 1'b0;
    end else if (bus_stop) begin
      state_d    = ST_IDLE;
      have_bit_d = 1'b0;
      sda_oe_d   = 1'b0;
    end else if (state_q == ST_DEV_ADDR || state_q == ST_REG_ADDR ||
                 state_q == ST_DATA) begin
      if (scl_rise) begin
        shift_d    = {shift_q[6:0], sda_sync_q};
        have_bit_d = 1'b1;
      end else if (scl_fall && have_bit_q) begin
        have_bit_d = 1'b0;
        if (bit_cnt_q == 3'd7) begin
          bit_cnt_d = 3'd0;
          if (state_q == ST_DEV_ADDR) begin
            // R/W bit is ignored: every access is handled as a write.
            if (shift_q[7:1] == DEV_ADDR) begin
              state_d  = ST_DEV_ACK;
              sda_oe_d = 1'b1;
            end else begin
              state_d  = ST_IGNORE;
            end
          end else if (state_q == ST_REG_ADDR) begin
            reg_ptr_d = shift_q;
            state_d   = ST_REG_ACK;
            sda_oe_d  = 1'b1;
          end else begin
            // addr/data_in only change here, so they hold between strobes.
            data_in_d       = shift_q;
            addr_d          = reg_ptr_q;
            data_in_ready_d = 1'b1;
`ifdef I2C_SLAVE_AUTO_INC_EN
            reg_ptr_d       = reg_ptr_q + 8'd1;
`else
            reg_ptr_d       = reg_ptr_q;
`endif
            state_d         = ST_DATA_ACK;
            sda_oe_d        = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
    end else if (state_q == ST_DEV_ACK || state_q == ST_REG_ACK ||
                 state_q == ST_DATA_ACK) begin
      if (scl_fall) begin
        sda_oe_d   = 1'b0;
        bit_cnt_d  = 3'd0;
        have_bit_d = 1'b0;
        state_d    = (state_q == ST_DEV_ACK) ? ST_REG_ADDR : ST_DATA;
      end
    end
  end

  // All state, including the synchronizers, lives in this one register block.
  // Synchronizers reset to the idle-bus level (both lines high).
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_meta_q      <= 1'b1;
      scl_sync_q      <= 1'b1;
      scl_prev_q      <= 1'b1;
      sda_meta_q      <= 1'b1;
      sda_sync_q      <= 1'b1;
      sda_prev_q      <= 1'b1;
      state_q         <= ST_IDLE;
      shift_q         <= 8'd0;
      bit_cnt_q       <= 3'd0;
      have_bit_q      <= 1'b0;
      sda_oe_q        <= 1'b0;
      reg_ptr_q       <= 8'd0;
      addr_q          <= 8'd0;
      data_in_q       <= 8'd0;
      data_in_ready_q <= 1'b0;
    end else begin
      scl_meta_q      <= pin_scl;
      scl_sync_q      <= scl_meta_q;
      scl_prev_q      <= scl_sync_q;
      sda_meta_q      <= pin_sda;
      sda_sync_q      <= sda_meta_q;
      sda_prev_q      <= sda_sync_q;
      state_q         <= state_d;
      shift_q         <= shift_d;
      bit_cnt_q       <= bit_cnt_d;
      have_bit_q      <= have_bit_d;
      sda_oe_q        <= sda_oe_d;
      reg_ptr_q       <= reg_ptr_d;
      addr_q          <= addr_d;
      data_in_q       <= data_in_d;
      data_in_ready_q <= data_in_ready_d;
    end
  end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// tb_i2c_slave_rx
// Directed bench for i2c_slave_rx: plays the I2C controller on pin_scl/pin_sda,
// watches the data_in_ready strobe and compares against hand-computed values.
module tb_i2c_slave_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tb_scl;
  logic       tb_sda_low;
  wire        pin_sda;
  logic [7:0] addr;
  logic [7:0] data_in;
  logic       data_in_ready;

  int         checks = 0;
  int         failures = 0;
  int         strobe_count = 0;
  int         wide_strobes = 0;
  int         exp_strobes = 0;
  logic [7:0] cap_addr = 8'h00;
  logic [7:0] cap_data = 8'h00;
  logic       prev_ready = 1'b0;
  logic       dut_low_seen = 1'b0;

  // Controller side of the open-drain SDA line plus the bus pull-up.
  assign pin_sda = tb_sda_low ? 1'b0 : 1'bz;
  pullup (pin_sda);

  always #5 clk = ~clk;

  i2c_slave_rx #(.DEV_ADDR(7'h1A)) dut (
    .clk           (clk),
    .rst           (rst),
    .pin_scl       (tb_scl),
    .pin_sda       (pin_sda),
    .addr          (addr),
    .data_in       (data_in),
    .data_in_ready (data_in_ready)
  );

  // Strobe monitor on the falling clk edge: counts strobes, captures the
  // reported pair, flags strobes longer than one cycle and notes any time the
  // DUT pulls SDA low.
  always @(negedge clk) begin
    if (data_in_ready === 1'b1) begin
      strobe_count++;
      cap_addr = addr;
      cap_data = data_in;
      if (prev_ready === 1'b1) wide_strobes++;
    end
    prev_ready = data_in_ready;
    if (pin_sda === 1'b0 && !tb_sda_low) dut_low_seen = 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One data bit: setup, SCL high, SCL low with hold.
  task automatic applyStimulus(input logic b);
    tb_sda_low = !b;
    waitCycles(6);
    tb_scl = 1'b1;
    waitCycles(8);
    tb_scl = 1'b0;
    waitCycles(6);
  endtask

  // START (also usable as repeated START from SCL low).
  task automatic busStart();
    tb_sda_low = 1'b0;
    waitCycles(6);
    tb_scl = 1'b1;
    waitCycles(8);
    tb_sda_low = 1'b1;
    waitCycles(8);
    tb_scl = 1'b0;
    waitCycles(6);
  endtask

  task automatic busStop();
    tb_sda_low = 1'b1;
    waitCycles(6);
    tb_scl = 1'b1;
    waitCycles(8);
    tb_sda_low = 1'b0;
    waitCycles(8);
  endtask

  // Eight data bits then the ACK clock; checks the ACK level while SCL is
  // high and that SDA is released again after the 9th falling edge.
  task automatic writeByte(input logic [7:0] b, input logic exp_ack,
                           input string tag);
    for (int i = 7; i >= 0; i--) applyStimulus(b[i]);
    tb_sda_low = 1'b0;
    waitCycles(6);
    tb_scl = 1'b1;
    waitCycles(4);
    checkOutput({tag, "_ack"}, {31'd0, pin_sda === 1'b0}, {31'd0, exp_ack});
    waitCycles(4);
    tb_scl = 1'b0;
    waitCycles(6);
    checkOutput({tag, "_release"}, {31'd0, pin_sda}, 32'd1);
  endtask

  task automatic checkStrobe(input string tag, input logic [7:0] exp_addr,
                             input logic [7:0] exp_data);
    checkOutput({tag, "_count"}, strobe_count, exp_strobes);
    checkOutput({tag, "_addr"}, {24'd0, cap_addr}, {24'd0, exp_addr});
    checkOutput({tag, "_data"}, {24'd0, cap_data}, {24'd0, exp_data});
  endtask

  initial begin
    rst        = 1'b1;
    tb_scl     = 1'b1;
    tb_sda_low = 1'b0;
    waitCycles(4);
    rst = 1'b0;
    waitCycles(4);
    checkOutput("reset_addr", {24'd0, addr}, 32'd0);
    checkOutput("reset_data", {24'd0, data_in}, 32'd0);
    checkOutput("reset_ready", {31'd0, data_in_ready}, 32'd0);
    checkOutput("reset_sda", {31'd0, pin_sda}, 32'd1);

    $display("[TB] single write 0x35 0x75 0x74");
    busStart();
    writeByte(8'h35, 1'b1, "t1_dev");
    writeByte(8'h75, 1'b1, "t1_reg");
    writeByte(8'h74, 1'b1, "t1_data");
    busStop();
    exp_strobes = 1;
    checkStrobe("t1_strobe", 8'h75, 8'h74);
    checkOutput("t1_sda_idle", {31'd0, pin_sda}, 32'd1);

    $display("[TB] same write twice back-to-back");
    for (int k = 0; k < 2; k++) begin
      busStart();
      writeByte(8'h35, 1'b1, "t2_dev");
      writeByte(8'h75, 1'b1, "t2_reg");
      writeByte(8'h74, 1'b1, "t2_data");
      busStop();
      exp_strobes++;
      checkStrobe("t2_strobe", 8'h75, 8'h74);
    end

    $display("[TB] foreign device address 0x11");
    dut_low_seen = 1'b0;
    busStart();
    writeByte(8'h22, 1'b0, "t3_dev");
    writeByte(8'h75, 1'b0, "t3_reg");
    writeByte(8'h74, 1'b0, "t3_data");
    busStop();
    checkOutput("t3_sda_driven", {31'd0, dut_low_seen}, 32'd0);
    checkOutput("t3_count", strobe_count, exp_strobes);
    checkOutput("t3_addr", {24'd0, addr}, 32'h75);
    checkOutput("t3_data", {24'd0, data_in}, 32'h74);

    $display("[TB] two data bytes 0xAA 0xBB at register 0x10");
    busStart();
    writeByte(8'h34, 1'b1, "t4_dev");
    writeByte(8'h10, 1'b1, "t4_reg");
    writeByte(8'hAA, 1'b1, "t4_d0");
    exp_strobes++;
    checkStrobe("t4_s0", 8'h10, 8'hAA);
    writeByte(8'hBB, 1'b1, "t4_d1");
    exp_strobes++;
`ifdef I2C_SLAVE_AUTO_INC_EN
    checkStrobe("t4_s1", 8'h11, 8'hBB);
`else
    checkStrobe("t4_s1", 8'h10, 8'hBB);
`endif
    busStop();

    $display("[TB] register 0xFF with two data bytes");
    busStart();
    writeByte(8'h34, 1'b1, "t5_dev");
    writeByte(8'hFF, 1'b1, "t5_reg");
    writeByte(8'h01, 1'b1, "t5_d0");
    exp_strobes++;
    checkStrobe("t5_s0", 8'hFF, 8'h01);
    writeByte(8'h02, 1'b1, "t5_d1");
    exp_strobes++;
`ifdef I2C_SLAVE_AUTO_INC_EN
    checkStrobe("t5_s1", 8'h00, 8'h02);
`else
    checkStrobe("t5_s1", 8'hFF, 8'h02);
`endif
    busStop();

    $display("[TB] reset in the middle of a data byte");
    busStart();
    writeByte(8'h34, 1'b1, "t6_dev");
    writeByte(8'h66, 1'b1, "t6_reg");
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    rst = 1'b1;
    waitCycles(2);
    rst = 1'b0;
    waitCycles(2);
    checkOutput("t6_rst_addr", {24'd0, addr}, 32'd0);
    checkOutput("t6_rst_data", {24'd0, data_in}, 32'd0);
    checkOutput("t6_rst_ready", {31'd0, data_in_ready}, 32'd0);
    checkOutput("t6_rst_sda", {31'd0, pin_sda}, 32'd1);
    checkOutput("t6_rst_count", strobe_count, exp_strobes);
    busStart();
    writeByte(8'h34, 1'b1, "t6b_dev");
    writeByte(8'h05, 1'b1, "t6b_reg");
    writeByte(8'h3C, 1'b1, "t6b_data");
    busStop();
    exp_strobes++;
    checkStrobe("t6_strobe", 8'h05, 8'h3C);

    $display("[TB] repeated START after the register byte");
    busStart();
    writeByte(8'h34, 1'b1, "t7_dev");
    writeByte(8'h40, 1'b1, "t7_reg");
    busStart();
    writeByte(8'h34, 1'b1, "t7b_dev");
    writeByte(8'h20, 1'b1, "t7b_reg");
    writeByte(8'h55, 1'b1, "t7b_data");
    busStop();
    exp_strobes++;
    checkStrobe("t7_strobe", 8'h20, 8'h55);

    waitCycles(4);
    checkOutput("strobe_width", wide_strobes, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
